// File: rtl/rvvi_ack_responder.sv
// rvvi_ack_responder: filters RVVI trace frames from the MAC RX stream and returns ack frames on the TX stream; define RVVI_ACK_SEQCHECK_EN to enable frame-count sequence checking
module rvvi_ack_responder #(
    parameter int FRAME_COUNT_WIDTH = 64,
    parameter int ACK_WORDS = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] RvviAxiRdata,
    input  logic [3:0]  RvviAxiRstrb,
    input  logic        RvviAxiRvalid,
    input  logic        RvviAxiRlast,
    output logic [31:0] AckAxiWdata,
    output logic [3:0]  AckAxiWstrb,
    output logic        AckAxiWvalid,
    output logic        AckAxiWlast,
    input  logic        AckAxiWready,
    input  logic [47:0] HostMac,
    input  logic [15:0] EthType,
    input  logic [15:0] AckType,
    input  logic [31:0] InterPacketDelay,
    output logic [31:0] AckCount,
    output logic [31:0] DropCount,
    output logic        SeqError
);
    localparam logic [2:0] LastWord = 3'(ACK_WORDS - 1);
    typedef enum logic {Idle, Send} TxState;
    function automatic logic [31:0] byteSwap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction
    logic [2:0] rxCount;
    logic [31:0] rxWord0, rxWord1, rxWord2, rxWord4, rxWord5;
    logic [15:0] rxTypeWord;
    logic [3:0] rxStrb5;
    logic [31:0] word5Now, swap0, swap1, swap2;
    logic [3:0] strb5Now;
    logic [47:0] rxDst, rxSrc;
    logic [15:0] rxType;
    logic [FRAME_COUNT_WIDTH-1:0] rxFrameCount;
    logic frameEnd, accept;
    logic pending;
    logic [47:0] slotMac, snapMac;
    logic [FRAME_COUNT_WIDTH-1:0] slotCount, snapCount;
    TxState state, nextState;
    logic [2:0] txIndex;
    logic startTx, beatDone;
    logic [31:0] txWords [8];
    // RX word position: saturates past the header, restarts after every last beat
    always_ff @(posedge clk) begin
        if (reset) rxCount <= '0;
        else if (RvviAxiRvalid) rxCount <= RvviAxiRlast ? 3'd0 : (rxCount == 3'd6 ? rxCount : rxCount + 3'd1);
    end
    // Header word capture; only the EtherType half of word 3 matters
    always_ff @(posedge clk) begin
        if (RvviAxiRvalid) begin
            if (rxCount == 3'd0) rxWord0 <= RvviAxiRdata;
            if (rxCount == 3'd1) rxWord1 <= RvviAxiRdata;
            if (rxCount == 3'd2) rxWord2 <= RvviAxiRdata;
            if (rxCount == 3'd3) rxTypeWord <= RvviAxiRdata[15:0];
            if (rxCount == 3'd4) rxWord4 <= RvviAxiRdata;
            if (rxCount == 3'd5) begin
                rxWord5 <= RvviAxiRdata;
                rxStrb5 <= RvviAxiRstrb;
            end
        end
    end
    // Header decode; word 5 may still be on the bus when a 6-word frame ends
    always_comb begin
        word5Now = rxCount == 3'd5 ? RvviAxiRdata : rxWord5;
        strb5Now = rxCount == 3'd5 ? RvviAxiRstrb : rxStrb5;
        swap0 = byteSwap(rxWord0);
        swap1 = byteSwap(rxWord1);
        swap2 = byteSwap(rxWord2);
        rxDst = {swap0, swap1[31:16]};
        rxSrc = {swap1[15:0], swap2};
        rxType = {rxTypeWord[7:0], rxTypeWord[15:8]};
        rxFrameCount = {word5Now, rxWord4};
        frameEnd = RvviAxiRvalid & RvviAxiRlast;
        accept = frameEnd && rxCount >= 3'd5 && rxDst == HostMac && rxType == EthType && strb5Now == 4'hF;
        startTx = state == Idle && pending;
        beatDone = state == Send && AckAxiWready;
    end
    // Pending flag and drop counter; a new accept wins over the snapshot clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            DropCount <= '0;
        end else begin
            pending <= accept | (pending & ~startTx);
            if (frameEnd && !accept) DropCount <= DropCount + 32'd1;
        end
    end
    // Pending slot (newest frame wins) and TX snapshot taken from the old slot value
    always_ff @(posedge clk) begin
        if (accept) begin
            slotMac <= rxSrc;
            slotCount <= rxFrameCount;
        end
        if (startTx) begin
            snapMac <= slotMac;
            snapCount <= slotCount;
        end
    end
    // TX state register
    always_ff @(posedge clk) begin
        state <= reset ? Idle : nextState;
    end
    // TX next state: leave SEND only after the last word is accepted
    always_comb begin
        nextState = state == Idle ? (pending ? Send : Idle) : (AckAxiWready && txIndex == LastWord ? Idle : Send);
    end
    // TX word index and completed-ack counter
    always_ff @(posedge clk) begin
        if (reset) begin
            txIndex <= '0;
            AckCount <= '0;
        end else begin
            txIndex <= startTx ? 3'd0 : (beatDone ? txIndex + 3'd1 : txIndex);
            if (beatDone && txIndex == LastWord) AckCount <= AckCount + 32'd1;
        end
    end
    // TX outputs: ack words built from registered snapshot, so they hold while stalled
    always_comb begin
        txWords[0] = byteSwap(snapMac[47:16]);
        txWords[1] = byteSwap({snapMac[15:0], HostMac[47:32]});
        txWords[2] = byteSwap(HostMac[31:0]);
        txWords[3] = byteSwap({EthType, AckType});
        txWords[4] = snapCount[31:0];
        txWords[5] = snapCount[63:32];
        txWords[6] = InterPacketDelay;
        txWords[7] = '0;
        AckAxiWvalid = state == Send;
        AckAxiWdata = AckAxiWvalid ? txWords[txIndex] : '0;
        AckAxiWstrb = AckAxiWvalid ? 4'hF : 4'h0;
        AckAxiWlast = AckAxiWvalid && txIndex == LastWord;
    end
`ifdef RVVI_ACK_SEQCHECK_EN
    logic [FRAME_COUNT_WIDTH-1:0] prevCount;
    logic havePrev;
    // Sticky sequence check; the first accepted frame after reset only seeds the history
    always_ff @(posedge clk) begin
        if (reset) begin
            havePrev <= 1'b0;
            SeqError <= 1'b0;
        end else if (accept) begin
            havePrev <= 1'b1;
            prevCount <= rxFrameCount;
            if (havePrev && rxFrameCount != prevCount + 1'b1) SeqError <= 1'b1;
        end
    end
`else
    assign SeqError = 1'b0;
`endif
endmodule
